// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment read-back path.
// Patterns are {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h40;
  localparam logic [6:0] SEG7_1     = 7'h79;
  localparam logic [6:0] SEG7_2     = 7'h24;
  localparam logic [6:0] SEG7_3     = 7'h30;
  localparam logic [6:0] SEG7_4     = 7'h19;
  localparam logic [6:0] SEG7_5     = 7'h12;
  localparam logic [6:0] SEG7_6     = 7'h02;
  localparam logic [6:0] SEG7_7     = 7'h78;
  localparam logic [6:0] SEG7_8     = 7'h00;
  localparam logic [6:0] SEG7_9     = 7'h18;
  localparam logic [6:0] SEG7_A     = 7'h08;
  localparam logic [6:0] SEG7_B     = 7'h03;
  localparam logic [6:0] SEG7_C     = 7'h46;
  localparam logic [6:0] SEG7_D     = 7'h21;
  localparam logic [6:0] SEG7_E     = 7'h06;
  localparam logic [6:0] SEG7_F     = 7'h0E;
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  typedef enum logic {ACCUM, HOLD} state_t;

endpackage

// File: rtl/seg7_word_encoder_if.sv
// Digit stream in, packed word out; master is the host/bench side, slave is the encoder.
interface seg7_word_encoder_if #(
  parameter int unsigned NUM_DIGITS = 6
);
  logic [6:0]              seg_in;
  logic                    seg_valid;
  logic                    seg_ready;
  logic                    flush;
  logic [4*NUM_DIGITS-1:0] word_out;
  logic [NUM_DIGITS-1:0]   word_err;
  logic                    word_valid;
  logic                    word_ready;

  modport master (
    output seg_in, seg_valid, flush, word_ready,
    input  seg_ready, word_out, word_err, word_valid
  );

  modport slave (
    input  seg_in, seg_valid, flush, word_ready,
    output seg_ready, word_out, word_err, word_valid
  );
endinterface

// File: rtl/seg7_encoder.sv
// Combinational segment-pattern to hex-nibble decode; unknown patterns give 0 and flag invalid.
module seg7_encoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] nibble,
  output logic       invalid
);

  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (seg_in)
      SEG7_0:  nibble = 4'h0;
      SEG7_1:  nibble = 4'h1;
      SEG7_2:  nibble = 4'h2;
      SEG7_3:  nibble = 4'h3;
      SEG7_4:  nibble = 4'h4;
      SEG7_5:  nibble = 4'h5;
      SEG7_6:  nibble = 4'h6;
      SEG7_7:  nibble = 4'h7;
      SEG7_8:  nibble = 4'h8;
      SEG7_9:  nibble = 4'h9;
      SEG7_A:  nibble = 4'hA;
      SEG7_B:  nibble = 4'hB;
      SEG7_C:  nibble = 4'hC;
      SEG7_D:  nibble = 4'hD;
      SEG7_E:  nibble = 4'hE;
      SEG7_F:  nibble = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_word_encoder.sv
// Packs NUM_DIGITS decoded segment digits into one word with per-digit error flags.
module seg7_word_encoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_word_encoder_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);

  state_t                  state;
  logic [IDX_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] word_q, word_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    word_valid_q;
  logic [3:0]              nibble;
  logic                    invalid;
  logic                    accept, last, close;

  seg7_encoder u_encoder (
    .seg_in  (bus.seg_in),
    .nibble  (nibble),
    .invalid (invalid)
  );

  assign accept = bus.seg_valid && (state == ACCUM);
  assign last   = accept && (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign close  = last || (bus.flush && (state == ACCUM) && (accept || digit_idx != '0));

  // Slots at or above digit_idx that this cycle does not write are unwritten:
  // padded on close, otherwise cleared when a new word starts.
  always_comb begin
    word_d = word_q;
    err_d  = err_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (accept && i == 32'(digit_idx)) begin
        word_d[4*i +: 4] = nibble;
        err_d[i]         = invalid;
      end else if (close && i >= 32'(digit_idx)) begin
        word_d[4*i +: 4] = 4'h0;
        err_d[i]         = 1'b1;
      end else if (accept && digit_idx == '0) begin
        word_d[4*i +: 4] = 4'h0;
        err_d[i]         = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      digit_idx    <= '0;
      word_q       <= '0;
      err_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          word_q <= word_d;
          err_q  <= err_d;
          if (accept)
            digit_idx <= digit_idx + 1'b1;
          if (close) begin
            state        <= HOLD;
            word_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.word_ready) begin
            state        <= ACCUM;
            digit_idx    <= '0;
            word_valid_q <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.seg_ready  = (state == ACCUM);
  assign bus.word_out   = word_q;
  assign bus.word_err   = err_q;
  assign bus.word_valid = word_valid_q;

endmodule

// File: doc/seg7_word_encoder.md
Name: seg7_word_encoder

Overview:
- Reverse path of the board's 7-segment display: accepts active-low segment patterns one digit at a time over a valid/ready stream, encodes each back to a 4-bit hex nibble, and packs NUM_DIGITS nibbles into one word.
- The packed word is presented on a valid/ready output with per-digit error flags.
- Used by the self-check logic to read back what the HEX display is driven with, and to capture segment streams from the test host.

Parameters:
- NUM_DIGITS, 6, digits per packed word (HEX0..HEX5); legal range 1..8.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment pattern {g,f,e,d,c,b,a}, active low.
- seg_valid  input  1  seg_in carries a digit.
- seg_ready  output  1  block accepts a digit this cycle.
- flush  input  1  close the current partial word early.
- word_out  output  4*NUM_DIGITS  packed nibbles; first accepted digit is in [3:0].
- word_err  output  NUM_DIGITS  bit i set = digit i was non-canonical or padded.
- word_valid  output  1  word_out/word_err hold a complete word.
- word_ready  input  1  consumer takes the word.

Behaviour:
- Canonical table, pattern -> nibble:
  - 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7
  - 0x00->8, 0x18->9, 0x08->A, 0x03->B, 0x46->C, 0x21->D, 0x06->E, 0x0E->F
  - Any other pattern, including blank 0x7F, encodes to nibble 0 and sets that digit's err bit.
- FSM has two states, ACCUM and HOLD. Reset state is ACCUM.
- seg_ready = (state==ACCUM); this is combinational from the state register.
- Reset values: digit_idx=0, word_out=0, word_err=0, word_valid=0. seg_ready therefore reads 1 while rst_n is low and after reset.
- ACCUM:
  - On seg_valid&&seg_ready, write the encoded nibble to slot digit_idx and its err bit to word_err[digit_idx], then digit_idx++.
  - If the accepted digit is slot NUM_DIGITS-1, go to HOLD. word_valid rises on the next edge, so there is 1-cycle latency from the last digit to word_valid.
- Start of a word: on the first accepted digit of a word (digit_idx==0), all slots above 0 clear to nibble 0, err 0. No stale data from the previous word survives.
- Flush in ACCUM:
  - If digit_idx>0, or a digit is accepted in the same cycle, every slot not yet written is padded with nibble 0 and err 1, and the FSM goes to HOLD.
  - Flush with digit_idx==0 and no accept is ignored.
  - If a digit is accepted in the same cycle, it is stored first, then padding applies. If that digit fills the word, there is nothing to pad.
- HOLD:
  - word_valid=1; word_out and word_err stay stable until the handshake.
  - seg_ready=0 and flush is ignored.
  - On word_ready, go to ACCUM, digit_idx=0, and word_valid drops on the next edge. word_out keeps its value until the next word starts.
- Throughput: one bubble cycle per word, because seg_ready is 0 in the handshake cycle. Maximum rate is NUM_DIGITS digits per NUM_DIGITS+1 cycles.
- digit_idx width is $clog2(NUM_DIGITS+1); it never exceeds NUM_DIGITS-1 in ACCUM.
- Reset asserted mid-word or in HOLD discards all partial state immediately (asynchronous). No word is emitted.
- seg_in is sampled only on handshake cycles. Values while seg_valid=0 have no effect.

Decomposition:
- Package seg7_pkg holds:
  - the 16 canonical pattern constants (SEG7_0..SEG7_F);
  - SEG7_BLANK = 7'h7F;
  - the state enum typedef {ACCUM, HOLD}.
- Sub-module seg7_encoder is purely combinational: seg_in[6:0] -> nibble[3:0] and invalid. It is instantiated once.

Test Plan:
- Reset, then 6 accepted digits 0x79,0x24,0x30,0x19,0x12,0x02 with word_ready=1 -> word_valid one cycle after the last digit, word_out=24'h654321, word_err=6'b000000, then seg_ready returns to 1 after one bubble.
- Feed digits 0x08,0x03,0x46,0x21,0x06,0x0E with word_ready held 0 for 10 cycles -> word_out=24'hFEDCBA stable, seg_ready=0 throughout, a seg_valid pulse during HOLD is not accepted; handshake releases it.
- Digits 0x40,0x79,0x7F,0x55,0x78,0x00 -> word_out=24'h870010, word_err=6'b001100.
- Accept 0x08 then 0x03, assert flush alone -> word_out=24'h0000BA, word_err=6'b111100. Flush with digit_idx==0 -> no word_valid.
- Flush coincident with acceptance of the 6th digit -> normal word, word_err=0. Flush with the 3rd digit 0x30 -> word_out=24'h000321, word_err=6'b111000.
- Deassert rst_n after 3 accepted digits -> outputs return to reset values asynchronously. The next 6 digits form a clean word with no carry-over.
